// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage. Results land after a
// fixed busy window. Defining MD_MADD_EN adds madd (MDop=100), which accumulates into {HI,LO}.
//
// state  | meaning
// S_IDLE | no operation in flight; mthi/mtlo accepted, start launches
// S_BUSY | counting down busy cycles; pending result commits at terminal count
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic        HIwrite,
  input  logic        LOwrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend_res;
  logic             pend_commit;
`ifdef MD_MADD_EN
  logic             pend_madd;
  logic             op_madd;
`endif

  logic             op_valid;
  logic             op_div;
  logic             op_signed;
  logic [CNT_W-1:0] op_len;
  logic [63:0]      a_ext;
  logic [63:0]      b_ext;
  logic [63:0]      prod;
  logic [31:0]      a_mag;
  logic [31:0]      b_mag;
  logic [31:0]      dvs;
  logic [31:0]      quo;
  logic [31:0]      rem;
  logic [31:0]      quo_s;
  logic [31:0]      rem_s;
  logic [63:0]      res;
  logic             res_commit;

  always_comb begin
    op_valid  = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    op_len    = '0;
`ifdef MD_MADD_EN
    op_madd   = 1'b0;
`endif
    case (MDop)
      3'b000: begin
        op_valid = 1'b1;
        op_len   = CNT_W'(MULT_CYCLES);
      end
      3'b001: begin
        op_valid  = 1'b1;
        op_signed = 1'b1;
        op_len    = CNT_W'(MULT_CYCLES);
      end
      3'b010: begin
        op_valid = 1'b1;
        op_div   = 1'b1;
        op_len   = CNT_W'(DIV_CYCLES);
      end
      3'b011: begin
        op_valid  = 1'b1;
        op_div    = 1'b1;
        op_signed = 1'b1;
        op_len    = CNT_W'(DIV_CYCLES);
      end
`ifdef MD_MADD_EN
      3'b100: begin
        op_valid  = 1'b1;
        op_signed = 1'b1;
        op_madd   = 1'b1;
        op_len    = CNT_W'(MULT_CYCLES);
      end
`endif
      default: ;
    endcase
  end

  // One 64x64 multiplier serves both signednesses: the low 64 bits of the extended product are exact.
  assign a_ext = op_signed ? {{32{A[31]}}, A} : {32'b0, A};
  assign b_ext = op_signed ? {{32{B[31]}}, B} : {32'b0, B};
  assign prod  = a_ext * b_ext;

  // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_mag = (op_signed && A[31]) ? -A : A;
  assign b_mag = (op_signed && B[31]) ? -B : B;
  assign dvs   = (B == 32'd0) ? 32'd1 : b_mag;
  assign quo   = a_mag / dvs;
  assign rem   = a_mag % dvs;
  assign quo_s = (op_signed && (A[31] ^ B[31])) ? -quo : quo;
  assign rem_s = (op_signed && A[31]) ? -rem : rem;

  assign res        = op_div ? {rem_s, quo_s} : prod;
  assign res_commit = !(op_div && (B == 32'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      cnt         <= '0;
      HI          <= 32'd0;
      LO          <= 32'd0;
      pend_res    <= 64'd0;
      pend_commit <= 1'b0;
`ifdef MD_MADD_EN
      pend_madd   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_valid) begin
              pend_res    <= res;
              pend_commit <= res_commit;
`ifdef MD_MADD_EN
              pend_madd   <= op_madd;
`endif
              cnt         <= op_len;
              busy        <= 1'b1;
              state       <= S_BUSY;
            end
          end else begin
            if (HIwrite) HI <= A;
            if (LOwrite) LO <= A;
          end
        end
        S_BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            if (pend_commit) begin
`ifdef MD_MADD_EN
              if (pend_madd) {HI, LO} <= {HI, LO} + pend_res;
              else           {HI, LO} <= pend_res;
`else
              {HI, LO} <= pend_res;
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a driver pushes expected HI/LO and busy length per operation,
// and a monitor checks them whenever a busy window opens and closes.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDop;
  logic        HIwrite;
  logic        LOwrite;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDop(MDop),
    .HIwrite(HIwrite), .LOwrite(LOwrite), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [31:0] new_hi;
    logic [31:0] new_lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       output logic [31:0] nh, output logic [31:0] nl,
                       output bit defd, output int len);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = hi; nl = lo; defd = 1'b0; len = 0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; defd = 1; len = 5; end
      3'd1: begin p = 64'(sa * sb); {nh, nl} = p; defd = 1; len = 5; end
      3'd2: begin
        defd = 1; len = 10;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      3'd3: begin
        defd = 1; len = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
`ifdef MD_MADD_EN
      3'd4: begin p = {hi, lo} + 64'(sa * sb); {nh, nl} = p; defd = 1; len = 5; end
`endif
      default: ;
    endcase
  endtask

  // Monitor: old contents must be visible in the first busy cycle, new ones when busy drops.
  logic prev_busy = 1'b0;
  int   mon_cnt = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_busy: got busy=1 expected no operation at %0t", $time);
        cur = '{32'd0, 32'd0, 32'd0, 32'd0, 0};
      end else begin
        cur = sb_q.pop_front();
        check("hi_during_busy", {32'd0, HI}, {32'd0, cur.old_hi});
        check("lo_during_busy", {32'd0, LO}, {32'd0, cur.old_lo});
      end
      mon_cnt = 1;
    end else if (busy) begin
      mon_cnt++;
    end
    if (!busy && prev_busy) begin
      check("busy_len", 64'(mon_cnt), 64'(cur.len));
      check("hi_commit", {32'd0, HI}, {32'd0, cur.new_hi});
      check("lo_commit", {32'd0, LO}, {32'd0, cur.new_lo});
    end
    prev_busy = busy;
  end

  task automatic mt(input bit hw, input bit lw, input logic [31:0] a);
    @(posedge clk); #1;
    HIwrite = hw; LOwrite = lw; A = a;
    @(posedge clk); #1;
    HIwrite = 0; LOwrite = 0;
    if (hw) m_hi = a;
    if (lw) m_lo = a;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [31:0] nh, nl;
    bit          defd;
    int          len, cyc;
    model(op, a, b, m_hi, m_lo, nh, nl, defd, len);
    if (defd) sb_q.push_back('{m_hi, m_lo, nh, nl, len});
    @(posedge clk); #1;
    start = 1; MDop = op; A = a; B = b; HIwrite = noise; LOwrite = noise;
    @(posedge clk); #1;
    start = 0; HIwrite = 0; LOwrite = 0; A = $urandom; B = $urandom;
    if (!defd) begin
      @(negedge clk);
      check("undef_busy", {63'd0, busy}, 64'd0);
    end else begin
      if (noise) begin
        @(posedge clk); #1;
        start = 1; MDop = 3'($urandom_range(0, 3)); HIwrite = 1; LOwrite = 1;
        @(posedge clk); #1;
        start = 0; HIwrite = 0; LOwrite = 0;
      end
      cyc = 0;
      while (busy && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (busy) check("busy_timeout", {63'd0, busy}, 64'd0);
      m_hi = nh; m_lo = nl;
    end
  endtask

  task automatic reset_mid_divu();
    sb_q.push_back('{m_hi, m_lo, 32'd0, 32'd0, 4});
    @(posedge clk); #1;
    start = 1; MDop = 3'b010; A = 32'd1000; B = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("post_reset_busy", {63'd0, busy}, 64'd0);
    check("post_reset_hilo", {HI, LO}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    reset = 1; start = 0; MDop = 0; HIwrite = 0; LOwrite = 0; A = 0; B = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);

    do_op(3'b001, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(3'b000, 32'hFFFF_FFFF, 32'd2, 0);
    do_op(3'b011, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    mt(1, 0, 32'h1234);
    mt(0, 1, 32'h5678);
    do_op(3'b010, 32'd99, 32'd0, 0);
    do_op(3'b011, 32'd99, 32'd0, 0);
    mt(1, 1, 32'hCAFE_F00D);
    mt(1, 0, 32'd0);
    mt(0, 1, 32'hFFFF_FFFF);
    do_op(3'b100, 32'd1, 32'd1, 0);
    do_op(3'b111, 32'd5, 32'd6, 1);
    reset_mid_divu();

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'($urandom));
      do_op(rop, ra, rb, $urandom_range(0, 2) == 0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("final_hilo", {HI, LO}, {m_hi, m_lo});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
